// File: rtl/player_health_if.sv
// player_health_if
//   Groups the frame/hit stimulus and the health status outputs of one
//   player_health tracker.
//   master : the game-logic side; drives frame_tick/hit/damage and
//            observes health and status.
//   slave  : the player_health tracker itself.
//   Signals:
//     frame_tick    - one-cycle pulse per video frame
//     hit           - one-cycle pulse: the player was struck
//     damage[9:0]   - damage amount, meaningful only with hit
//     player_health - current health (to score counter and HUD)
//     alive         - player is in ALIVE or INVULN
//     invulnerable  - player is in INVULN
//     respawn_pulse - one-cycle pulse when health is restored after death
interface player_health_if;
  logic       frame_tick;
  logic       hit;
  logic [9:0] damage;
  logic [9:0] player_health;
  logic       alive;
  logic       invulnerable;
  logic       respawn_pulse;

  modport master (
    output frame_tick, hit, damage,
    input  player_health, alive, invulnerable, respawn_pulse
  );

  modport slave (
    input  frame_tick, hit, damage,
    output player_health, alive, invulnerable, respawn_pulse
  );
endinterface

// File: rtl/player_health.sv
// player_health
//   Per-player health tracker. Applies damage from hit events, enforces a
//   post-hit invulnerability window counted in frame ticks, and on a lethal
//   hit holds health at zero for a respawn delay before restoring full
//   health with spawn protection. Health sits at zero for a whole respawn
//   window so the downstream score counter sees one nonzero-to-zero edge
//   per death.
//   Parameters:
//     MAX_HEALTH     - health after reset and after respawn (1..1023)
//     INVULN_FRAMES  - frame ticks of invulnerability (1..1023)
//     RESPAWN_FRAMES - frame ticks health is held at zero (1..1023)
//   Ports:
//     Clk   - system clock, all state changes on its rising edge
//     Reset - synchronous active-high reset
//     bus   - player_health_if.slave (stimulus in, registered status out)
module player_health #(
  parameter logic [9:0] MAX_HEALTH     = 10'd100,
  parameter logic [9:0] INVULN_FRAMES  = 10'd30,
  parameter logic [9:0] RESPAWN_FRAMES = 10'd120
) (
  input  logic            Clk,
  input  logic            Reset,
  player_health_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [9:0] cnt_r;
  logic [9:0] cnt_s;
  logic [9:0] health_r;
  logic [9:0] health_s;
  logic       alive_r;
  logic       alive_s;
  logic       invuln_r;
  logic       invuln_s;
  logic       pulse_r;
  logic       pulse_s;

  // Next-state, next-counter and next-output computation.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    health_s = health_r;
    pulse_s  = 1'b0;

    case (state_r)
      ST_ALIVE: begin
        // A simultaneous frame_tick is deliberately not counted: the new
        // window is loaded in full.
        if (bus.hit && (bus.damage != 10'd0)) begin
          if (bus.damage >= health_r) begin
            health_s = 10'd0;
            state_s  = ST_DEAD;
            cnt_s    = RESPAWN_FRAMES;
          end else begin
            health_s = health_r - bus.damage;
            state_s  = ST_INVULN;
            cnt_s    = INVULN_FRAMES;
          end
        end else begin
          state_s = ST_ALIVE;
        end
      end

      ST_INVULN: begin
        // Hits are ignored for the whole window, including its last tick.
        if (bus.frame_tick) begin
          if (cnt_r == 10'd1) begin
            state_s = ST_ALIVE;
            cnt_s   = 10'd0;
          end else begin
            cnt_s = cnt_r - 10'd1;
          end
        end else begin
          state_s = ST_INVULN;
        end
      end

      ST_DEAD: begin
        if (bus.frame_tick) begin
          if (cnt_r == 10'd1) begin
            health_s = MAX_HEALTH;
            state_s  = ST_INVULN;
            cnt_s    = INVULN_FRAMES;
            pulse_s  = 1'b1;
          end else begin
            cnt_s = cnt_r - 10'd1;
          end
        end else begin
          state_s = ST_DEAD;
        end
      end

      default: begin
        // Unreachable encoding: recover to a full-health live player.
        state_s  = ST_ALIVE;
        cnt_s    = 10'd0;
        health_s = MAX_HEALTH;
      end
    endcase

    alive_s  = (state_s != ST_DEAD);
    invuln_s = (state_s == ST_INVULN);
  end

  // State, counter and registered output flops with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r  <= ST_ALIVE;
      cnt_r    <= 10'd0;
      health_r <= MAX_HEALTH;
      alive_r  <= 1'b1;
      invuln_r <= 1'b0;
      pulse_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      health_r <= health_s;
      alive_r  <= alive_s;
      invuln_r <= invuln_s;
      pulse_r  <= pulse_s;
    end
  end

  assign bus.player_health = health_r;
  assign bus.alive         = alive_r;
  assign bus.invulnerable  = invuln_r;
  assign bus.respawn_pulse = pulse_r;

endmodule

// File: tb/tb_player_health.sv
// tb_player_health
//   Directed scoreboard bench for player_health with MAX_HEALTH=100,
//   INVULN_FRAMES=3, RESPAWN_FRAMES=5. Each stimulus cycle pushes the
//   expected registered outputs; they are popped and compared one cycle
//   later, after the clock edge.
module tb_player_health;

  logic Clk;
  logic Reset;

  player_health_if bus ();

  player_health #(
    .MAX_HEALTH     (10'd100),
    .INVULN_FRAMES  (10'd3),
    .RESPAWN_FRAMES (10'd5)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string      tag;
    logic [9:0] health;
    logic       alive;
    logic       invuln;
    logic       pulse;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;

  // 50 MHz clock.
  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, push expectation, clock, pop and compare.
  task automatic cyc(input string tag, input bit rst, input bit h, input logic [9:0] d,
                     input bit t, input logic [9:0] eh, input bit ea, input bit ei,
                     input bit ep);
    exp_t e;
    exp_t o;
    Reset          = rst;
    bus.hit        = h;
    bus.damage     = d;
    bus.frame_tick = t;
    e.tag = tag; e.health = eh; e.alive = ea; e.invuln = ei; e.pulse = ep;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue"}, 10'd0, 10'd1);
    end else begin
      o = exp_q.pop_front();
      check_val({o.tag, "_health"}, bus.player_health, o.health);
      check_val({o.tag, "_alive"}, {9'd0, bus.alive}, {9'd0, o.alive});
      check_val({o.tag, "_invuln"}, {9'd0, bus.invulnerable}, {9'd0, o.invuln});
      check_val({o.tag, "_pulse"}, {9'd0, bus.respawn_pulse}, {9'd0, o.pulse});
    end
    Reset          = 1'b0;
    bus.hit        = 1'b0;
    bus.damage     = 10'd0;
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    Reset          = 1'b1;
    bus.hit        = 1'b0;
    bus.damage     = 10'd0;
    bus.frame_tick = 1'b0;
    @(posedge Clk);
    #1;

    // Reset values
    cyc("rst0", 1, 0, 10'd0, 0, 10'd100, 1, 0, 0);
    cyc("rst1", 1, 0, 10'd0, 0, 10'd100, 1, 0, 0);

    // Zero damage: no change
    cyc("zero_dmg", 0, 1, 10'd0, 0, 10'd100, 1, 0, 0);

    // Non-lethal hit, back-to-back second hit ignored
    cyc("hit30", 0, 1, 10'd30, 0, 10'd70, 1, 1, 0);
    cyc("hit30_b2b", 0, 1, 10'd30, 0, 10'd70, 1, 1, 0);
    cyc("inv_tick1", 0, 0, 10'd0, 1, 10'd70, 1, 1, 0);
    cyc("inv_idle", 0, 1, 10'd20, 0, 10'd70, 1, 1, 0);
    cyc("inv_tick2", 0, 0, 10'd0, 1, 10'd70, 1, 1, 0);
    // Hit on the final INVULN tick is ignored
    cyc("inv_tick3_hit", 0, 1, 10'd30, 1, 10'd70, 1, 0, 0);
    // Hit one cycle later is applied
    cyc("hit30_again", 0, 1, 10'd30, 0, 10'd40, 1, 1, 0);
    cyc("w2_tick1", 0, 0, 10'd0, 1, 10'd40, 1, 1, 0);
    cyc("w2_tick2", 0, 0, 10'd0, 1, 10'd40, 1, 1, 0);
    cyc("w2_tick3", 0, 0, 10'd0, 1, 10'd40, 1, 0, 0);
    cyc("alive_tick", 0, 0, 10'd0, 1, 10'd40, 1, 0, 0);

    // Lethal hit and respawn
    cyc("lethal50", 0, 1, 10'd50, 0, 10'd0, 0, 0, 0);
    cyc("dead_hit", 0, 1, 10'd10, 0, 10'd0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc($sformatf("dead_tick%0d", i), 0, 0, 10'd0, 1, 10'd0, 0, 0, 0);
      cyc($sformatf("dead_idle%0d", i), 0, 0, 10'd0, 0, 10'd0, 0, 0, 0);
    end
    // Hit on the respawn tick is ignored
    cyc("respawn", 0, 1, 10'd60, 1, 10'd100, 1, 1, 1);
    cyc("post_respawn", 0, 1, 10'd60, 0, 10'd100, 1, 1, 0);
    cyc("sp_tick1", 0, 0, 10'd0, 1, 10'd100, 1, 1, 0);
    cyc("sp_tick2", 0, 0, 10'd0, 1, 10'd100, 1, 1, 0);
    cyc("sp_tick3", 0, 0, 10'd0, 1, 10'd100, 1, 0, 0);

    // Hit with frame_tick in ALIVE: full 3-tick window follows
    cyc("hit_and_tick", 0, 1, 10'd10, 1, 10'd90, 1, 1, 0);
    cyc("hat_tick1", 0, 0, 10'd0, 1, 10'd90, 1, 1, 0);
    cyc("hat_tick2", 0, 0, 10'd0, 1, 10'd90, 1, 1, 0);
    cyc("hat_tick3", 0, 0, 10'd0, 1, 10'd90, 1, 0, 0);
    cyc("hit99_to_1", 0, 1, 10'd89, 0, 10'd1, 1, 1, 0);

    // Exact-kill boundary, then reset mid-DEAD
    cyc("rst_a", 1, 0, 10'd0, 0, 10'd100, 1, 0, 0);
    cyc("exact_kill", 0, 1, 10'd100, 0, 10'd0, 0, 0, 0);
    cyc("md_tick1", 0, 0, 10'd0, 1, 10'd0, 0, 0, 0);
    cyc("md_tick2", 0, 0, 10'd0, 1, 10'd0, 0, 0, 0);
    cyc("rst_mid_dead", 1, 0, 10'd0, 1, 10'd100, 1, 0, 0);
    for (int i = 3; i <= 6; i++) begin
      cyc($sformatf("after_rst_tick%0d", i), 0, 0, 10'd0, 1, 10'd100, 1, 0, 0);
    end

    // Max damage, full respawn, then reset mid-INVULN
    cyc("dmg1023", 0, 1, 10'd1023, 0, 10'd0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc($sformatf("d2_tick%0d", i), 0, 0, 10'd0, 1, 10'd0, 0, 0, 0);
    end
    cyc("d2_respawn", 0, 0, 10'd0, 1, 10'd100, 1, 1, 1);
    cyc("rst_mid_inv", 1, 0, 10'd0, 0, 10'd100, 1, 0, 0);
    cyc("just_alive", 0, 1, 10'd99, 0, 10'd1, 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
